// File: rtl/bram_pipe.sv
// rtl/bram_pipe.sv - single-port-pair block RAM with clear sequencer, byte enables and pipelined reads
module bram_pipe #(
  parameter int ADDR_WIDTH = 3,
  parameter int RAM_DEPTH = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int READ_NB_FFD = 1,
  parameter int RDW_MODE = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    srst,
  output logic                    ready,
  input  logic                    wren,
  input  logic [ADDR_WIDTH-1:0]   wraddr,
  input  logic [DATA_WIDTH/8-1:0] wrbe,
  input  logic [DATA_WIDTH-1:0]   wrdata,
  input  logic                    rden,
  input  logic [ADDR_WIDTH-1:0]   rdaddr,
  output logic [DATA_WIDTH-1:0]   rddata,
  output logic                    rdvalid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  // One extra bit so a full power-of-two depth is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic                  wr_ok;
  logic                  rd_in_range;
  logic                  rd_ok;
  logic                  rdw_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rdw_word;
  logic [DATA_WIDTH-1:0] rd_result;

  logic [READ_NB_FFD-1:0] vld_pipe;
  logic [DATA_WIDTH-1:0]  dat_pipe [READ_NB_FFD];

  // Requests are only honoured once the clear has finished; out-of-range addresses drop writes.
  assign wr_ok       = (state == READY) && wren && ({1'b0, wraddr} < DEPTH);
  assign rd_in_range = ({1'b0, rdaddr} < DEPTH);
  assign rd_ok       = (state == READY) && rden;
  assign rdw_hit     = wr_ok && rd_ok && (wraddr == rdaddr);

  // Read word selection: zero for out-of-range, optional bypass of a same-cycle write.
  always_comb begin
    rd_word  = rd_in_range ? mem[rdaddr] : '0;
    rdw_word = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (wrbe[i]) rdw_word[8*i +: 8] = wrdata[8*i +: 8];
    end
    rd_result = (RDW_MODE == 1 && rdw_hit) ? rdw_word : rd_word;
  end

  // Clear sequencer: walks every address once after reset, then hands over to READY.
  always_ff @(posedge clk) begin
    if (srst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      if (clr_cnt == LAST) begin
        state   <= READY;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Memory array: clear writes in CLEAR, byte-lane writes in READY; no reset on contents.
  always_ff @(posedge clk) begin
    if (!srst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= INIT_VALUE;
      end else if (wr_ok) begin
        for (int i = 0; i < NB; i++) begin
          if (wrbe[i]) mem[wraddr][8*i +: 8] <= wrdata[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline: data stages only load behind a valid, so the output holds between pulses.
  always_ff @(posedge clk) begin
    if (srst) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_NB_FFD; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_ok;
      if (rd_ok) dat_pipe[0] <= rd_result;
      for (int i = 1; i < READ_NB_FFD; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign ready   = (state == READY);
  assign rdvalid = vld_pipe[READ_NB_FFD-1];
  assign rddata  = dat_pipe[READ_NB_FFD-1];

endmodule

// File: tb/tb_bram_pipe.sv
// tb/tb_bram_pipe.sv - scoreboard bench for bram_pipe across three parameter sets
module tb_bram_pipe;

  logic clk;
  int   cyc;
  int   nchk;
  int   nfail;

  // Instance A: defaults (8-bit, latency 1, old-data RDW)
  logic       srst_a, ready_a, wren_a, rden_a, rdvalid_a;
  logic [2:0] wraddr_a, rdaddr_a;
  logic [0:0] wrbe_a;
  logic [7:0] wrdata_a, rddata_a;
  // Instance B: 32-bit, latency 3, new-data RDW
  logic        srst_b, ready_b, wren_b, rden_b, rdvalid_b;
  logic [2:0]  wraddr_b, rdaddr_b;
  logic [3:0]  wrbe_b;
  logic [31:0] wrdata_b, rddata_b;
  // Instance C: depth 6 with 3-bit addresses
  logic       srst_c, ready_c, wren_c, rden_c, rdvalid_c;
  logic [2:0] wraddr_c, rdaddr_c;
  logic [0:0] wrbe_c;
  logic [7:0] wrdata_c, rddata_c;

  logic [31:0] qd_a[$], qd_b[$], qd_c[$];
  int          qc_a[$], qc_b[$], qc_c[$];

  bram_pipe u_a (
    .clk(clk), .srst(srst_a), .ready(ready_a), .wren(wren_a), .wraddr(wraddr_a),
    .wrbe(wrbe_a), .wrdata(wrdata_a), .rden(rden_a), .rdaddr(rdaddr_a),
    .rddata(rddata_a), .rdvalid(rdvalid_a)
  );

  bram_pipe #(.DATA_WIDTH(32), .READ_NB_FFD(3), .RDW_MODE(1)) u_b (
    .clk(clk), .srst(srst_b), .ready(ready_b), .wren(wren_b), .wraddr(wraddr_b),
    .wrbe(wrbe_b), .wrdata(wrdata_b), .rden(rden_b), .rdaddr(rdaddr_b),
    .rddata(rddata_b), .rdvalid(rdvalid_b)
  );

  bram_pipe #(.RAM_DEPTH(6)) u_c (
    .clk(clk), .srst(srst_c), .ready(ready_c), .wren(wren_c), .wraddr(wraddr_c),
    .wrbe(wrbe_c), .wrdata(wrdata_c), .rden(rden_c), .rdaddr(rdaddr_c),
    .rddata(rddata_c), .rdvalid(rdvalid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitors: pop the scoreboard whenever a read result is presented
  always @(negedge clk) begin
    if (rdvalid_a) begin
      if (qd_a.size() == 0) chk("a_unexpected_rdvalid", {31'b0, rdvalid_a}, 32'd0);
      else begin
        chk("a_rddata", {24'b0, rddata_a}, qd_a.pop_front());
        chk("a_latency", cyc, qc_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rdvalid_b) begin
      if (qd_b.size() == 0) chk("b_unexpected_rdvalid", {31'b0, rdvalid_b}, 32'd0);
      else begin
        chk("b_rddata", rddata_b, qd_b.pop_front());
        chk("b_latency", cyc, qc_b.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rdvalid_c) begin
      if (qd_c.size() == 0) chk("c_unexpected_rdvalid", {31'b0, rdvalid_c}, 32'd0);
      else begin
        chk("c_rddata", {24'b0, rddata_c}, qd_c.pop_front());
        chk("c_latency", cyc, qc_c.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request cycle on an instance; a read pushes its expected word and arrival cycle
  task automatic op(int inst, bit we, logic [2:0] wa, logic [31:0] wd, logic [3:0] be,
                    bit re, logic [2:0] ra, logic [31:0] exp);
    case (inst)
      0: begin
        wren_a = we; wraddr_a = wa; wrdata_a = wd[7:0]; wrbe_a = be[0:0];
        rden_a = re; rdaddr_a = ra;
        if (re) begin qd_a.push_back(exp); qc_a.push_back(cyc + 1); end
      end
      1: begin
        wren_b = we; wraddr_b = wa; wrdata_b = wd; wrbe_b = be;
        rden_b = re; rdaddr_b = ra;
        if (re) begin qd_b.push_back(exp); qc_b.push_back(cyc + 3); end
      end
      default: begin
        wren_c = we; wraddr_c = wa; wrdata_c = wd[7:0]; wrbe_c = be[0:0];
        rden_c = re; rdaddr_c = ra;
        if (re) begin qd_c.push_back(exp); qc_c.push_back(cyc + 1); end
      end
    endcase
    step();
    wren_a = 1'b0; rden_a = 1'b0;
    wren_b = 1'b0; rden_b = 1'b0;
    wren_c = 1'b0; rden_c = 1'b0;
  endtask

  function automatic logic rdy(int inst);
    case (inst)
      0: return ready_a;
      1: return ready_b;
      default: return ready_c;
    endcase
  endfunction

  // Counts cycles from the current (first post-reset) cycle until ready rises
  task automatic wait_ready(int inst, int expn);
    int n;
    n = 0;
    while (!rdy(inst) && n < 40) begin
      step();
      n++;
    end
    chk($sformatf("ready_latency_%0d", inst), n, expn);
  endtask

  initial begin
    nchk = 0; nfail = 0; cyc = 0;
    srst_a = 1'b1; srst_b = 1'b1; srst_c = 1'b1;
    wren_a = 0; wraddr_a = 0; wrbe_a = 0; wrdata_a = 0; rden_a = 0; rdaddr_a = 0;
    wren_b = 0; wraddr_b = 0; wrbe_b = 0; wrdata_b = 0; rden_b = 0; rdaddr_b = 0;
    wren_c = 0; wraddr_c = 0; wrbe_c = 0; wrdata_c = 0; rden_c = 0; rdaddr_c = 0;
    step();
    step();

    // Reset state on all three instances
    chk("rst_ready_a", {31'b0, ready_a}, 0);
    chk("rst_rdvalid_a", {31'b0, rdvalid_a}, 0);
    chk("rst_rddata_a", {24'b0, rddata_a}, 0);
    chk("rst_ready_b", {31'b0, ready_b}, 0);
    chk("rst_rdvalid_b", {31'b0, rdvalid_b}, 0);
    chk("rst_rddata_b", rddata_b, 0);
    chk("rst_ready_c", {31'b0, ready_c}, 0);
    chk("rst_rddata_c", {24'b0, rddata_c}, 0);

    // A: requests held during clear must be ignored (no rdvalid, addr 0 stays cleared)
    srst_a = 1'b0;
    wren_a = 1'b1; wraddr_a = 3'd0; wrdata_a = 8'h55; wrbe_a = 1'b1;
    rden_a = 1'b1; rdaddr_a = 3'd0;
    wait_ready(0, 8);
    wren_a = 1'b0; rden_a = 1'b0;
    for (int i = 0; i < 8; i++) op(0, 0, 3'd0, 0, 4'h0, 1, 3'(i), 32'h00);

    // A: fill then stream 8 back-to-back reads
    for (int i = 0; i < 8; i++) op(0, 1, 3'(i), 32'h30 + 32'(i), 4'h1, 0, 3'd0, 0);
    for (int i = 0; i < 8; i++) op(0, 0, 3'd0, 0, 4'h0, 1, 3'(i), 32'h30 + 32'(i));
    step(); step(); step();
    chk("a_hold_rddata", {24'b0, rddata_a}, 32'h37);
    chk("a_hold_rdvalid", {31'b0, rdvalid_a}, 0);

    // A: old-data read during write, then the new word one cycle later
    op(0, 1, 3'd2, 32'h10, 4'h1, 0, 3'd0, 0);
    op(0, 1, 3'd2, 32'h20, 4'h1, 1, 3'd2, 32'h10);
    op(0, 0, 3'd0, 0, 4'h0, 1, 3'd2, 32'h20);
    // A: write with no byte enables leaves memory alone
    op(0, 1, 3'd3, 32'hEE, 4'h0, 0, 3'd0, 0);
    op(0, 0, 3'd0, 0, 4'h0, 1, 3'd3, 32'h33);
    step(); step();

    // A: reset in the middle of the clear restarts it from address 0
    srst_a = 1'b1; step(); srst_a = 1'b0;
    step(); step(); step(); step();
    srst_a = 1'b1; step();
    chk("a_midclear_rddata", {24'b0, rddata_a}, 0);
    srst_a = 1'b0;
    wait_ready(0, 8);
    op(0, 0, 3'd0, 0, 4'h0, 1, 3'd2, 32'h00);
    step(); step();

    // B: byte-enable merge with 3-cycle latency
    srst_b = 1'b0;
    wait_ready(1, 8);
    op(1, 1, 3'd5, 32'hAABBCCDD, 4'hF, 0, 3'd0, 0);
    op(1, 1, 3'd5, 32'h11223344, 4'b0101, 0, 3'd0, 0);
    op(1, 0, 3'd0, 0, 4'h0, 1, 3'd5, 32'hAA22CC44);
    // B: new-data read during write, full and partial lanes
    op(1, 1, 3'd2, 32'h10, 4'hF, 0, 3'd0, 0);
    op(1, 1, 3'd2, 32'h20, 4'hF, 1, 3'd2, 32'h20);
    op(1, 1, 3'd2, 32'h00003300, 4'b0010, 1, 3'd2, 32'h00003320);
    op(1, 0, 3'd0, 0, 4'h0, 1, 3'd2, 32'h00003320);
    step(); step(); step(); step();

    // B: two reads in flight are discarded by reset, memory is cleared again
    rden_b = 1'b1; rdaddr_b = 3'd5;
    step(); step();
    rden_b = 1'b0; srst_b = 1'b1;
    step();
    srst_b = 1'b0;
    wait_ready(1, 8);
    op(1, 0, 3'd0, 0, 4'h0, 1, 3'd5, 32'h0);
    step(); step(); step(); step();

    // C: shallow memory, out-of-range write ignored and read returns zero
    srst_c = 1'b0;
    wait_ready(2, 6);
    op(2, 1, 3'd7, 32'hFF, 4'h1, 0, 3'd0, 0);
    op(2, 1, 3'd5, 32'h5A, 4'h1, 0, 3'd0, 0);
    op(2, 0, 3'd0, 0, 4'h0, 1, 3'd7, 32'h00);
    op(2, 0, 3'd0, 0, 4'h0, 1, 3'd5, 32'h5A);
    op(2, 0, 3'd0, 0, 4'h0, 1, 3'd6, 32'h00);
    op(2, 0, 3'd0, 0, 4'h0, 1, 3'd0, 32'h00);
    step(); step(); step();

    chk("a_drain", qd_a.size(), 0);
    chk("b_drain", qd_b.size(), 0);
    chk("c_drain", qd_c.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
